sumador_rr_sched: RTL and testbench
===================================

// Module: sumador_rr_sched
// PURPOSE
//  Round-robin scheduler that shares one SUMADORQ22 adder (5-bit a/b, 6-bit c)
//  between N_REQ requesters. Arbitrates, latches the winner's operands, drives
//  the adder, waits its pipeline latency, and returns sum plus requester id
//  over a valid/ready response channel. One transaction is in flight at a time.
//  Sits between the top-level pin wrapper and the adder instance.
// PARAMETERS
//  N_REQ   4  number of requesters (2..8)
//  W       5  operand width; sum is W+1 bits
//  ADD_LAT 1  adder latency in cycles from add_a/add_b to add_sum (0 = combinational)
// PORTS
//  clk        in   1          clock, rising edge
//  rst_n      in   1          asynchronous active-low reset
//  req_valid  in   N_REQ      per-requester request
//  req_a      in   N_REQ*W    operand a, requester i at [i*W +: W]
//  req_b      in   N_REQ*W    operand b, same packing
//  req_ready  out  N_REQ      one-hot grant; request accepted when valid&ready
//  add_a      out  W          operand a to adder
//  add_b      out  W          operand b to adder
//  add_sum    in   W+1        adder result (carry in MSB)
//  rsp_valid  out  1          response available
//  rsp_ready  in   1          consumer accepts response
//  rsp_sum    out  W+1        captured sum
//  rsp_id     out  clog2(N)   index of requester that owns rsp_sum
//  busy       out  1          high whenever state != IDLE
//  op_count   out  8          completed responses, wraps 255->0
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, rr_ptr=0, op regs=0, cnt=0,
//   add_a/add_b=0, rsp_valid=0, rsp_sum=0, rsp_id=0, busy=0, op_count=0.
//   Reset mid-transaction drops it silently; no response is ever produced.
//  FSM IDLE -> WAIT -> RESP -> IDLE.
//  IDLE: winner = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ...
//   mod N_REQ. req_ready[winner]=1 combinationally that cycle only; all other
//   req_ready=0. At the edge: latch req_a/req_b[winner] into op regs, id=winner,
//   rr_ptr=(winner+1) mod N_REQ, cnt=ADD_LAT, go WAIT. No valid -> stay, ptr held.
//  req_ready is 0 in WAIT and RESP regardless of req_valid.
//  add_a/add_b are driven from the op regs (registered, stable through WAIT).
//  WAIT: cnt!=0 -> cnt--. cnt==0 -> capture add_sum into rsp_sum, set
//   rsp_valid=1, go RESP.
//  RESP: rsp_valid, rsp_sum, rsp_id held stable until rsp_ready. On
//   rsp_valid&rsp_ready: rsp_valid=0, op_count++, go IDLE.
//  Latency: grant cycle T -> rsp_valid first high at T+ADD_LAT+2. Minimum issue
//   interval ADD_LAT+3 cycles (grant, WAIT, RESP with rsp_ready=1, IDLE).
//  Width: no truncation; rsp_sum = add_sum (W+1 bits), e.g. 31+31 = 62.
//  Requester dropping req_valid before grant is legal; pointer is unaffected.
//  rr_ptr fairness: a continuously-valid requester waits at most N_REQ-1 grants.
// TESTING
//  1 req_valid=0001, a0=31, b0=31, rsp_ready=1 -> req_ready=0001 at T,
//    rsp_valid at T+3, rsp_sum=62, rsp_id=0, op_count=1.
//  2 all four valid continuously, a_i=i, b_i=1 -> grant order 0,1,2,3,0;
//    rsp_sum 1,2,3,4,1; grants spaced 4 cycles.
//  3 rr_ptr=2, only req_valid[1] -> grant 1 (wrap search), rr_ptr becomes 2.
//  4 rsp_ready=0 for 10 cycles in RESP -> rsp_valid/sum/id stable, req_ready=0,
//    busy=1; rsp_ready=1 -> IDLE the next cycle.
//  5 rst_n low during WAIT -> all outputs 0 immediately, no rsp; pending
//    req_valid=0100 after release -> granted with rr_ptr restarted from 0.
//  6 256 back-to-back transactions -> op_count wraps 255->0, no glitch on rsp.

Source files
------------

// File: rtl/sumador_rr_sched_if.sv
// Request/adder/response bundle between the pin wrapper, the scheduler and the shared adder.
interface sumador_rr_sched_if #(
    parameter int N_REQ = 4,
    parameter int W     = 5
);
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ*W-1:0] req_a;
    logic [N_REQ*W-1:0] req_b;
    logic [W-1:0]       add_a;
    logic [W-1:0]       add_b;
    logic [W:0]         add_sum;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [W:0]         rsp_sum;
    logic [IDW-1:0]     rsp_id;
    logic               busy;
    logic [7:0]         op_count;

    modport slave (
        input  req_valid, req_a, req_b, add_sum, rsp_ready,
        output req_ready, add_a, add_b, rsp_valid, rsp_sum, rsp_id, busy, op_count
    );

    modport master (
        output req_valid, req_a, req_b, add_sum, rsp_ready,
        input  req_ready, add_a, add_b, rsp_valid, rsp_sum, rsp_id, busy, op_count
    );
endinterface

// File: rtl/sumador_rr_sched.sv
// Round-robin scheduler sharing one adder among N_REQ requesters; one transaction in flight.
//  state  | meaning
//  S_IDLE | searching for a requester from rr_ptr, grant and latch operands
//  S_WAIT | operands on adder, counting down the adder latency
//  S_RESP | holding the captured sum until the consumer takes it
module sumador_rr_sched #(
    parameter int N_REQ   = 4,
    parameter int W       = 5,
    parameter int ADD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    sumador_rr_sched_if.slave  bus
);
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW  = (ADD_LAT > 0) ? $clog2(ADD_LAT + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [W-1:0]   op_a_q, op_a_d;
    logic [W-1:0]   op_b_q, op_b_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [W:0]     rsp_sum_q, rsp_sum_d;
    logic [7:0]     op_count_q, op_count_d;

    logic [IDW-1:0] winner;
    logic [IDW-1:0] cand;
    logic           found;

    // Walk the ring backwards so the candidate nearest rr_ptr is written last and wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = IDW'((int'(rr_ptr_q) + k) % N_REQ);
            if (bus.req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            op_count_q  <= op_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        op_count_d  = op_count_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    op_a_d   = W'(bus.req_a >> (int'(winner) * W));
                    op_b_d   = W'(bus.req_b >> (int'(winner) * W));
                    id_d     = winner;
                    rr_ptr_d = IDW'((int'(winner) + 1) % N_REQ);
                    cnt_d    = CW'(ADD_LAT);
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    rsp_sum_d   = bus.add_sum;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + 8'd1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        if (state_q == S_IDLE && found) begin
            bus.req_ready[winner] = 1'b1;
        end
        bus.busy = (state_q != S_IDLE);
    end

    assign bus.add_a     = op_a_q;
    assign bus.add_b     = op_b_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_id    = id_q;
    assign bus.op_count  = op_count_q;
endmodule

// File: tb/tb_sumador_rr_sched.sv
// Directed bench for sumador_rr_sched with a one-cycle registered adder model.
module tb_sumador_rr_sched;
    localparam int N = 4;
    localparam int W = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sumador_rr_sched_if #(.N_REQ(N), .W(W)) bus ();

    logic [W:0] add_sum_q = '0;
    always @(posedge clk) add_sum_q <= {1'b0, bus.add_a} + {1'b0, bus.add_b};
    assign bus.add_sum = add_sum_q;

    sumador_rr_sched #(.N_REQ(N), .W(W), .ADD_LAT(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic set_idx_ops();
        for (int i = 0; i < N; i++) begin
            bus.req_a[i*W +: W] = W'(i);
            bus.req_b[i*W +: W] = W'(1);
        end
    endtask

    task automatic wait_rsp(input string tag);
        int cyc = 0;
        while (!bus.rsp_valid && cyc < 20) begin
            step();
            cyc++;
        end
        if (!bus.rsp_valid) check_val({tag, " rsp timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_txn(input logic [N-1:0] vld, input int exp_id, input logic [W:0] exp_sum,
                           input string tag);
        bus.req_valid = vld;
        #1;
        check_val({tag, " grant"}, 32'(bus.req_ready), 32'd1 << exp_id);
        step();
        bus.req_valid = '0;
        wait_rsp(tag);
        check_val({tag, " sum"}, 32'(bus.rsp_sum), 32'(exp_sum));
        check_val({tag, " id"}, 32'(bus.rsp_id), 32'(exp_id));
        step();
        check_val({tag, " idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int exp_sum[5]   = '{1, 2, 3, 4, 1};
        int g, r, last, n;

        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b1;
        step();
        check_val("rst busy", 32'(bus.busy), 32'd0);
        check_val("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_val("rst op_count", 32'(bus.op_count), 32'd0);
        check_val("rst add_a", 32'(bus.add_a), 32'd0);
        check_val("rst rsp_sum", 32'(bus.rsp_sum), 32'd0);
        check_val("rst req_ready", 32'(bus.req_ready), 32'd0);
        step();
        rst_n = 1'b1;

        // 1: single request, exact latency and full-width sum
        bus.req_a[0 +: W] = 5'd31;
        bus.req_b[0 +: W] = 5'd31;
        bus.req_valid = 4'b0001;
        #1;
        check_val("t1 grant", 32'(bus.req_ready), 32'd1);
        step();
        bus.req_valid = '0;
        check_val("t1 busy", 32'(bus.busy), 32'd1);
        check_val("t1 ready in wait", 32'(bus.req_ready), 32'd0);
        check_val("t1 add_a", 32'(bus.add_a), 32'd31);
        step();
        check_val("t1 rsp T+2", 32'(bus.rsp_valid), 32'd0);
        step();
        check_val("t1 rsp T+3", 32'(bus.rsp_valid), 32'd1);
        check_val("t1 sum", 32'(bus.rsp_sum), 32'd62);
        check_val("t1 id", 32'(bus.rsp_id), 32'd0);
        step();
        check_val("t1 rsp done", 32'(bus.rsp_valid), 32'd0);
        check_val("t1 op_count", 32'(bus.op_count), 32'd1);
        check_val("t1 idle", 32'(bus.busy), 32'd0);

        // 2: all requesters valid, rotation and issue spacing
        do_reset();
        set_idx_ops();
        bus.req_valid = 4'hF;
        #1;
        g = 0; r = 0; last = 0;
        for (int cyc = 0; cyc < 60 && r < 5; cyc++) begin
            if (bus.req_ready != '0 && g < 5) begin
                check_val("t2 grant", 32'(bus.req_ready), 32'd1 << exp_order[g]);
                if (g > 0) check_val("t2 spacing", 32'(cyc - last), 32'd4);
                last = cyc;
                g++;
            end
            if (bus.rsp_valid) begin
                check_val("t2 sum", 32'(bus.rsp_sum), 32'(exp_sum[r]));
                check_val("t2 id", 32'(bus.rsp_id), 32'(exp_order[r]));
                r++;
                if (r == 5) bus.req_valid = '0;
            end
            if (r < 5) step();
        end
        check_val("t2 rsp count", 32'(r), 32'd5);
        step();

        // 3: wrap-around search and pointer after wrap (ptr is 1 here)
        run_txn(4'b0010, 1, 6'd2, "t3 ptr to 2");
        run_txn(4'b0010, 1, 6'd2, "t3 wrap");
        run_txn(4'b1010, 3, 6'd4, "t3 ptr held 2");

        // 4: consumer stalls for 10 cycles
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0100;
        #1;
        check_val("t4 grant", 32'(bus.req_ready), 32'd4);
        step();
        bus.req_valid = 4'hF;
        wait_rsp("t4");
        for (int i = 0; i < 10; i++) begin
            check_val("t4 hold valid", 32'(bus.rsp_valid), 32'd1);
            check_val("t4 hold sum", 32'(bus.rsp_sum), 32'd3);
            check_val("t4 hold id", 32'(bus.rsp_id), 32'd2);
            check_val("t4 hold ready", 32'(bus.req_ready), 32'd0);
            check_val("t4 hold busy", 32'(bus.busy), 32'd1);
            step();
        end
        bus.rsp_ready = 1'b1;
        bus.req_valid = '0;
        step();
        check_val("t4 release valid", 32'(bus.rsp_valid), 32'd0);
        check_val("t4 release busy", 32'(bus.busy), 32'd0);
        check_val("t4 op_count", 32'(bus.op_count), 32'd9);

        // 5: reset during WAIT drops the transaction (ptr is 3 here)
        bus.req_valid = 4'b0001;
        #1;
        check_val("t5 grant", 32'(bus.req_ready), 32'd1);
        step();
        bus.req_valid = '0;
        rst_n = 1'b0;
        #1;
        check_val("t5 rst busy", 32'(bus.busy), 32'd0);
        check_val("t5 rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_val("t5 rst add_a", 32'(bus.add_a), 32'd0);
        check_val("t5 rst add_b", 32'(bus.add_b), 32'd0);
        check_val("t5 rst op_count", 32'(bus.op_count), 32'd0);
        check_val("t5 rst rsp_sum", 32'(bus.rsp_sum), 32'd0);
        check_val("t5 rst rsp_id", 32'(bus.rsp_id), 32'd0);
        step();
        bus.req_valid = 4'b0100;
        step();
        check_val("t5 no rsp", 32'(bus.rsp_valid), 32'd0);
        rst_n = 1'b1;
        bus.req_valid = '0;
        run_txn(4'b0100, 2, 6'd3, "t5 pending");
        do_reset();
        run_txn(4'b1010, 1, 6'd2, "t5 ptr restart");

        // 6: 256 back-to-back transactions, op_count wrap
        do_reset();
        bus.req_a[0 +: W] = 5'd5;
        bus.req_b[0 +: W] = 5'd9;
        bus.req_valid = 4'b0001;
        n = 0;
        for (int cyc = 0; cyc < 1200 && n < 256; cyc++) begin
            if (bus.rsp_valid) begin
                check_val("t6 sum", 32'(bus.rsp_sum), 32'd14);
                check_val("t6 op_count", 32'(bus.op_count), 32'((n) & 255));
                n++;
                if (n == 256) bus.req_valid = '0;
            end
            step();
        end
        check_val("t6 count", 32'(n), 32'd256);
        check_val("t6 wrap", 32'(bus.op_count), 32'd0);
        check_val("t6 end valid", 32'(bus.rsp_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
